multu_hilo_unit: RTL
====================

Name: multu_hilo_unit

Overview:
- Execute-stage sequential unsigned multiplier that owns the architectural HI/LO register pair.
- It sits directly downstream of the ALU function decoder and consumes `mult_we` (start MULTU) and `mf_hilo_sel` (0 = HI, 1 = LO).
- It returns the selected HI/LO word to the register-file write-data mux, which is steered by `rf_wd_hilo_sel`.
- The multiply is radix-2 shift-add, one bit per cycle. It raises `mult_busy` so the hazard unit can stall dependent MFHI/MFLO and any new MULTU.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mult_we  input  1  start MULTU; sampled only when the unit is IDLE.
- src_a  input  WIDTH  multiplicand (rs).
- src_b  input  WIDTH  multiplier (rt).
- mf_hilo_sel  input  1  read select: 0 = HI, 1 = LO.
- mult_busy  output  1  high while a multiply is in flight.
- mult_done  output  1  one-cycle pulse in the first cycle after HI/LO are updated.
- hilo_rd  output  WIDTH  mf_hilo_sel ? lo : hi (combinational from the registers).
- hi  output  WIDTH  architectural HI register.
- lo  output  WIDTH  architectural LO register.

Behaviour:
- Reset is asynchronous on the falling edge of `rst_n`. While asserted:
  - state = IDLE;
  - `hi`, `lo`, accumulator and counter = 0;
  - `mult_busy` = 0, `mult_done` = 0, `hilo_rd` = 0.
- FSM has two states, IDLE and RUN.
- IDLE with `mult_we` = 1 at a rising edge:
  - latch `src_a` into the multiplicand register;
  - load the 2*WIDTH product register P = {WIDTH'b0, src_b};
  - clear counter to 0; go to RUN.
- IDLE with `mult_we` = 0: hold.
- RUN, one iteration per rising edge:
  - if P[0] = 1, form (WIDTH+1)-bit sum = {1'b0, P[2W-1:W]} + {1'b0, multiplicand}, else sum = {1'b0, P[2W-1:W]};
  - P <= {sum, P[W-1:1]} (a logical right shift that keeps the carry);
  - counter increments.
- Final iteration (counter = WIDTH-1):
  - the same edge writes `hi` <= new P[2W-1:W] and `lo` <= new P[W-1:0];
  - state returns to IDLE and `mult_done` is set for exactly one cycle.
- Latency:
  - `mult_busy` is high for exactly WIDTH cycles after the start edge;
  - the new HI/LO are visible on `hi`, `lo` and `hilo_rd` WIDTH cycles after the start edge.
- `mult_busy` = (state == RUN), registered-state derived with no combinational path from `mult_we`.
- HI/LO are written only at the final-iteration edge. Before that they keep the previous result, so a preempted read returns old data. The hazard unit must stall MFHI/MFLO while `mult_busy` = 1.
- `mult_we` while in RUN is ignored: operands are not relatched and there is no restart. The hazard unit must stall a second MULTU on `mult_busy`.
- `mult_we` in the same cycle as the final iteration is also ignored, because the state is RUN. It must be re-presented in IDLE.
- Operand changes on `src_a`/`src_b` after the start edge have no effect.
- Zero operands take the full WIDTH cycles; there is no early termination.
- Full unsigned result: `hi` = upper WIDTH bits and `lo` = lower WIDTH bits of src_a*src_b. There is no overflow and no sign handling.
- Reset asserted mid-RUN aborts the operation:
  - `hi`/`lo` clear to 0;
  - `mult_busy` drops immediately (asynchronously);
  - no `mult_done` pulse is generated.

Test Plan:
- Reset: hold `rst_n` = 0 and drive random inputs -> `hi` = `lo` = 0, `mult_busy` = 0, `hilo_rd` = 0. Release reset -> the unit stays IDLE with `mult_we` = 0.
- Basic: `src_a` = 3, `src_b` = 5, pulse `mult_we` -> `mult_busy` high for 32 cycles. Then `lo` = 0x0000000F, `hi` = 0, `mult_done` high for one cycle. `mf_hilo_sel` = 1 gives `hilo_rd` = 0x0000000F; `mf_hilo_sel` = 0 gives 0.
- Max operands: `src_a` = `src_b` = 0xFFFFFFFF -> `hi` = 0xFFFFFFFE, `lo` = 0x00000001 (carry-out path exercised).
- Old-value read and ignored start:
  - after the basic case, start 0x10000 * 0x10000;
  - at cycle 10, pulse `mult_we` with operands 7, 7 and read with `mf_hilo_sel` = 1 -> `hilo_rd` = 0x0000000F (old value);
  - the final result is `hi` = 0x00000001, `lo` = 0 (the second start is ignored).
- Reset mid-op: start 0xFFFFFFFF * 2, assert `rst_n` low at cycle 15 -> `mult_busy` drops immediately, `hi` = `lo` = 0, no `mult_done`. After release, 6*7 completes with `lo` = 42.
- Back-to-back: re-pulse `mult_we` in the first IDLE cycle after `mult_done` with operands 0x80000000 * 4 -> `hi` = 2, `lo` = 0 after a further 32 cycles.

Source files
------------

// File: rtl/multu_hilo_unit_if.sv
// Bus bundle between the ALU decode/hazard logic and the MULTU/HI-LO unit.
// The master drives the multiply request and read select; the slave returns status and HI/LO.
interface multu_hilo_unit_if #(
  parameter int WIDTH = 32
);
  logic             mult_we;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             mf_hilo_sel;
  logic             mult_busy;
  logic             mult_done;
  logic [WIDTH-1:0] hilo_rd;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output mult_we, src_a, src_b, mf_hilo_sel,
    input  mult_busy, mult_done, hilo_rd, hi, lo
  );

  modport slave (
    input  mult_we, src_a, src_b, mf_hilo_sel,
    output mult_busy, mult_done, hilo_rd, hi, lo
  );
endinterface

// File: rtl/multu_hilo_unit.sv
// Radix-2 shift-add unsigned multiplier, one bit per cycle, owning the HI/LO pair.
// HI/LO change only on the final iteration, so older results stay readable mid-operation.
module multu_hilo_unit #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  multu_hilo_unit_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  logic [0:0]         state_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [2*WIDTH-1:0] prod_r;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               done_r;

  logic [WIDTH:0]     addend_s;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] prod_nxt_s;
  logic               last_s;

  // One shift-add step; the sum keeps its carry bit so the shift is lossless.
  always_comb begin
    addend_s = {(WIDTH+1){1'b0}};
    if (prod_r[0]) begin
      addend_s = {1'b0, mcand_r};
    end else begin
      addend_s = {(WIDTH+1){1'b0}};
    end
    sum_s      = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + addend_s;
    prod_nxt_s = {sum_s, prod_r[WIDTH-1:1]};
    last_s     = (cnt_r == LAST_ITER);
  end

  // Control FSM, datapath registers and architectural HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      mcand_r <= {WIDTH{1'b0}};
      prod_r  <= {(2*WIDTH){1'b0}};
      cnt_r   <= {CW{1'b0}};
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.mult_we) begin
            mcand_r <= bus.src_a;
            prod_r  <= {{WIDTH{1'b0}}, bus.src_b};
            cnt_r   <= {CW{1'b0}};
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          prod_r <= prod_nxt_s;
          cnt_r  <= cnt_r + CW'(1);
          if (last_s) begin
            hi_r    <= prod_nxt_s[2*WIDTH-1:WIDTH];
            lo_r    <= prod_nxt_s[WIDTH-1:0];
            done_r  <= 1'b1;
            state_r <= IDLE;
          end else begin
            done_r  <= 1'b0;
            state_r <= RUN;
          end
        end
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mult_busy = (state_r == RUN);
  assign bus.mult_done = done_r;
  assign bus.hi        = hi_r;
  assign bus.lo        = lo_r;
  assign bus.hilo_rd   = bus.mf_hilo_sel ? lo_r : hi_r;
endmodule
